// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: state encodings and block geometry shared by the fill controller
package cache_fill_fsm_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;
  localparam int OFF_W = 3;
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
endpackage

// File: rtl/fill_counter.sv
// fill_counter: word counter with synchronous clear and increment, wraps modulo 2**W
module fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int W = OFF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : cnt + W'(inc);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches the 8-word block of a missed address and fills data and tag arrays
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_detected,
  input  logic [ADDR_W-1:0]         miss_address,
  input  logic                      memory_data_valid,
  input  logic [ADDR_W-1:0]         memory_data,
  output logic                      fsm_busy,
  output logic                      memory_enable,
  output logic [ADDR_W-1:0]         memory_address,
  output logic                      write_data_array,
  output logic [$clog2(WORDS)-1:0]  data_word,
  output logic [ADDR_W-1:0]         data_out,
  output logic                      write_tag_array,
  output logic [ADDR_W-1:0]         block_base
);
  localparam int OW = $clog2(WORDS);
  state_t state, state_nx;
  logic fill, accept, issue_done;
  logic [OW-1:0] issue_cnt, recv_cnt;
  always_comb begin
    fill             = state == ST_FILL;
    accept           = state == ST_IDLE && miss_detected;
    fsm_busy         = fill;
    memory_enable    = fill && !issue_done;
    memory_address   = block_base + ADDR_W'({issue_cnt, 1'b0});
    write_data_array = fill && memory_data_valid;
    data_word        = recv_cnt;
    data_out         = memory_data;
    write_tag_array  = write_data_array && recv_cnt == OW'(WORDS - 1);
    state_nx         = accept ? ST_FILL : write_tag_array ? ST_IDLE : state;
  end
  // issue_done stops requests once the last word has been asked for
  always_ff @(posedge clk) begin
    state      <= rst ? ST_IDLE : state_nx;
    issue_done <= (rst || accept) ? 1'b0 :
                  (memory_enable && issue_cnt == OW'(WORDS - 1)) ? 1'b1 : issue_done;
    block_base <= rst ? '0 : accept ? (miss_address & ADDR_W'(BLOCK_MASK)) : block_base;
  end
  fill_counter #(.W(OW)) issue_cnt_i (
    .clk(clk), .rst(rst), .clr(accept), .inc(memory_enable), .cnt(issue_cnt)
  );
  fill_counter #(.W(OW)) recv_cnt_i (
    .clk(clk), .rst(rst), .clr(accept), .inc(write_data_array), .cnt(recv_cnt)
  );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench with a 4-cycle memory model for cache_fill_fsm
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst, miss_detected, memory_data_valid;
  logic [15:0] miss_address, memory_data;
  logic fsm_busy, memory_enable, write_data_array, write_tag_array;
  logic [15:0] memory_address, data_out, block_base;
  logic [2:0] data_word;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .memory_enable(memory_enable), .memory_address(memory_address),
    .write_data_array(write_data_array), .data_word(data_word), .data_out(data_out),
    .write_tag_array(write_tag_array), .block_base(block_base)
  );

  typedef struct {int cyc; logic [15:0] a;} req_t;
  typedef struct {int due; logic [15:0] d;} ret_t;
  req_t req_q[$];
  ret_t ret_q[$];
  int cyc, checks, errors, nret, hold, gap_len, miss_cyc, tag_cyc;
  bit exp_busy;
  logic [15:0] exp_base;

  task automatic tick(input bit miss, input logic [15:0] ma, input bit r);
    bit vld, wr, tg, en, nx_busy;
    logic [15:0] d;
    req_t rq;
    ret_t rt;
    miss_detected = miss;
    miss_address  = ma;
    rst           = r;
    vld = 1'b0;
    d   = 16'($urandom);
    if (hold > 0) hold--;
    else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      vld = 1'b1;
      d   = ret_q[0].d;
      ret_q.delete(0);
    end
    memory_data_valid = vld;
    memory_data       = d;
    #1;
    wr = vld && exp_busy;
    tg = wr && nret == 7;
    en = req_q.size() > 0 && req_q[0].cyc == cyc;
    checks++;
    if (fsm_busy !== exp_busy) begin
      errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, fsm_busy, exp_busy);
    end
    checks++;
    if (block_base !== exp_base) begin
      errors++; $display("FAIL block_base cyc=%0d got=%h exp=%h", cyc, block_base, exp_base);
    end
    checks++;
    if (memory_enable !== en) begin
      errors++; $display("FAIL mem_en cyc=%0d got=%b exp=%b", cyc, memory_enable, en);
    end
    if (en) begin
      checks++;
      if (memory_address !== req_q[0].a) begin
        errors++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, memory_address, req_q[0].a);
      end
      rt.due = cyc + 4;
      rt.d   = req_q[0].a ^ 16'hC3A5;
      ret_q.push_back(rt);
      req_q.delete(0);
    end
    checks++;
    if (write_data_array !== wr) begin
      errors++; $display("FAIL wr_data cyc=%0d got=%b exp=%b", cyc, write_data_array, wr);
    end
    if (wr) begin
      checks++;
      if (data_word !== 3'(nret) || data_out !== d) begin
        errors++;
        $display("FAIL wr_word cyc=%0d got=%0d/%h exp=%0d/%h", cyc, data_word, data_out, nret, d);
      end
    end
    checks++;
    if (write_tag_array !== tg) begin
      errors++; $display("FAIL wr_tag cyc=%0d got=%b exp=%b", cyc, write_tag_array, tg);
    end
    if (write_tag_array === 1'b1) tag_cyc = cyc;
    nx_busy = exp_busy;
    if (wr) begin
      nret++;
      if (nret == 4 && gap_len > 0) hold = gap_len;
    end
    if (tg) nx_busy = 1'b0;
    if (r) begin
      nx_busy  = 1'b0;
      exp_base = 16'h0;
      nret     = 0;
      req_q.delete();
    end else if (miss && !exp_busy) begin
      nx_busy  = 1'b1;
      exp_base = ma & 16'hFFF0;
      nret     = 0;
      miss_cyc = cyc;
      for (int i = 0; i < 8; i++) begin
        rq.cyc = cyc + 1 + i;
        rq.a   = exp_base + 16'(2 * i);
        req_q.push_back(rq);
      end
    end
    exp_busy = nx_busy;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_busy || ret_q.size() > 0 || req_q.size() > 0) && n < limit) begin
      tick(1'b0, 16'h0, 1'b0);
      n++;
    end
    checks++;
    if (exp_busy || ret_q.size() > 0 || req_q.size() > 0) begin
      errors++; $display("FAIL drain_timeout got=busy exp=idle within %0d cycles", limit);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({fsm_busy, memory_enable, write_data_array, write_tag_array} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {fsm_busy, memory_enable, write_data_array, write_tag_array});
    end
    checks++;
    if (memory_address !== 16'h0 || block_base !== 16'h0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_buses got=%h/%h/%h exp=0", memory_address, block_base, data_out);
    end
    checks++;
    if (data_word !== 3'd0) begin
      errors++; $display("FAIL reset_word got=%0d exp=0", data_word);
    end
    repeat (2) tick(1'b0, 16'h0, 1'b1);
    repeat (2) tick(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_single_miss;
    tag_cyc = -1;
    tick(1'b1, 16'h1236, 1'b0);
    drain(40);
    checks++;
    if (tag_cyc - miss_cyc !== 12) begin
      errors++; $display("FAIL single_tag_lat got=%0d exp=12", tag_cyc - miss_cyc);
    end
  endtask

  task automatic test_gapped;
    tag_cyc = -1;
    gap_len = 3;
    tick(1'b1, 16'h2468, 1'b0);
    drain(40);
    gap_len = 0;
    checks++;
    if (tag_cyc - miss_cyc !== 15) begin
      errors++; $display("FAIL gapped_tag_lat got=%0d exp=15", tag_cyc - miss_cyc);
    end
  endtask

  task automatic test_miss_while_busy;
    tag_cyc = -1;
    tick(1'b1, 16'hA000, 1'b0);
    repeat (5) tick(1'b0, 16'h0, 1'b0);
    tick(1'b1, 16'h4000, 1'b0);
    drain(40);
    checks++;
    if (block_base !== 16'hA000 || tag_cyc - miss_cyc !== 12) begin
      errors++;
      $display("FAIL busy_miss got=%h/%0d exp=a000/12", block_base, tag_cyc - miss_cyc);
    end
  endtask

  task automatic test_reset_mid_fill;
    tag_cyc = -1;
    tick(1'b1, 16'h3000, 1'b0);
    repeat (5) tick(1'b0, 16'h0, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    drain(40);
    checks++;
    if (tag_cyc !== -1) begin
      errors++; $display("FAIL reset_fill_tag got=%0d exp=-1", tag_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int t1;
    tag_cyc = -1;
    tick(1'b1, 16'h1000, 1'b0);
    while (exp_busy && n < 40) begin
      tick(1'b0, 16'h0, 1'b0);
      n++;
    end
    t1 = tag_cyc;
    checks++;
    if (t1 - miss_cyc !== 12) begin
      errors++; $display("FAIL b2b_first_lat got=%0d exp=12", t1 - miss_cyc);
    end
    tick(1'b1, 16'hFFF2, 1'b0);
    drain(40);
    checks++;
    if (miss_cyc - t1 !== 1 || tag_cyc - miss_cyc !== 12) begin
      errors++;
      $display("FAIL b2b_second got=%0d/%0d exp=1/12", miss_cyc - t1, tag_cyc - miss_cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0;
    memory_data_valid = 1'b0;
    memory_data = 16'h0;
    cyc = 0; checks = 0; errors = 0; nret = 0; hold = 0; gap_len = 0;
    miss_cyc = 0; tag_cyc = -1; exp_busy = 1'b0; exp_base = 16'h0;
    test_reset;
    test_single_miss;
    test_gapped;
    test_miss_while_busy;
    test_reset_mid_fill;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
